// File: rtl/azadi_clk_div_gen.sv
// azadi_clk_div_gen: multi-channel programmable clock divider / clock-enable generator.
// Each channel divides clock_i by a runtime-programmable divisor. New divisors are staged
// and only take effect at a period boundary, so clk_o never glitches.
//
// Ports:
//   clock_i        single clock, posedge
//   reset_ni       asynchronous active-low reset
//   ch_en_i        per-channel run enable (level)
//   cfg_we_i       per-channel divisor write strobe
//   cfg_div_i      divisor write data, shared by all channels
//   sync_i         restart all running channels in phase
//   clk_o          divided clock per channel (registered)
//   tick_o         one-cycle pulse at the start of each period (registered)
//   cfg_pending_o  a written divisor is waiting to be applied
//   div_active_o   divisor in use, channel c at [c*DIV_W +: DIV_W]
module azadi_clk_div_gen #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 28,
  parameter int unsigned DEF_DIV = 5000
) (
  input  logic                    clock_i,
  input  logic                    reset_ni,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH-1:0]       cfg_we_i,
  input  logic [DIV_W-1:0]        cfg_div_i,
  input  logic                    sync_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o,
  output logic [NUM_CH-1:0]       cfg_pending_o,
  output logic [NUM_CH*DIV_W-1:0] div_active_o
);

  localparam logic [DIV_W-1:0] DefDiv = DIV_W'(DEF_DIV);

  logic [DIV_W-1:0]  r_cnt  [NUM_CH];
  logic [DIV_W-1:0]  r_div  [NUM_CH];
  logic [DIV_W-1:0]  r_pend [NUM_CH];
  logic [NUM_CH-1:0] r_pend_v;
  logic [NUM_CH-1:0] r_run;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_tick;

  logic [DIV_W-1:0]  w_cnt_nxt [NUM_CH];
  logic [DIV_W-1:0]  w_div_nxt [NUM_CH];
  logic [DIV_W:0]    w_half    [NUM_CH];
  logic [NUM_CH-1:0] w_run;
  logic [NUM_CH-1:0] w_wrap;
  logic [NUM_CH-1:0] w_apply;
  logic [NUM_CH-1:0] w_clk_nxt;
  logic [NUM_CH-1:0] w_tick_nxt;

  always_comb begin
    w_run      = '0;
    w_wrap     = '0;
    w_apply    = '0;
    w_clk_nxt  = '0;
    w_tick_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_run[c]  = ch_en_i[c] && (r_div[c] != '0);
      w_wrap[c] = (r_cnt[c] == r_div[c] - DIV_W'(1));
      // IDLE applies unconditionally; RUN only at the wrap or on a sync restart.
      w_apply[c]   = r_pend_v[c] && (!w_run[c] || w_wrap[c] || sync_i);
      w_div_nxt[c] = w_apply[c] ? r_pend[c] : r_div[c];

      if (!w_run[c]) begin
        w_cnt_nxt[c] = '0;
      end else if (!r_run[c] || sync_i || w_wrap[c]) begin
        w_cnt_nxt[c] = '0;
      end else begin
        w_cnt_nxt[c] = r_cnt[c] + DIV_W'(1);
      end

      // Extra bit keeps D+1 from overflowing when D is all ones.
      w_half[c] = ({1'b0, w_div_nxt[c]} + (DIV_W + 1)'(1)) >> 1;
      // Gating on the new divisor suppresses a stray pulse when 0 is applied at a wrap.
      w_clk_nxt[c]  = w_run[c] && (w_div_nxt[c] != '0) && ({1'b0, w_cnt_nxt[c]} < w_half[c]);
      w_tick_nxt[c] = w_run[c] && (w_div_nxt[c] != '0) && (w_cnt_nxt[c] == '0);
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c]  <= '0;
        r_div[c]  <= DefDiv;
        r_pend[c] <= DefDiv;
      end
      r_pend_v <= '0;
      r_run    <= '0;
      r_clk    <= '0;
      r_tick   <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= w_cnt_nxt[c];
        r_div[c] <= w_div_nxt[c];
        // A write in the same cycle as an apply wins and remains pending.
        if (cfg_we_i[c]) begin
          r_pend[c]   <= cfg_div_i;
          r_pend_v[c] <= 1'b1;
        end else if (w_apply[c]) begin
          r_pend_v[c] <= 1'b0;
        end
      end
      r_run  <= w_run;
      r_clk  <= w_clk_nxt;
      r_tick <= w_tick_nxt;
    end
  end

  always_comb begin
    div_active_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      div_active_o[c*DIV_W +: DIV_W] = r_div[c];
    end
  end

  assign clk_o         = r_clk;
  assign tick_o        = r_tick;
  assign cfg_pending_o = r_pend_v;

endmodule
